// File: rtl/parallel_pkg.sv
// Shared definitions for the parallel-link receive test sequencer.
package parallel_pkg;

    localparam int BLK_WORDS = 1024;
    localparam int DRAIN_CYC = 2;

    typedef enum logic [2:0] {
        IDLE, CLEAR, WAITLK, INITB, RUN, MARK, DRAIN, REPORT
    } state_t;

    typedef enum logic [2:0] {
        ST_NONE    = 3'd0,
        ST_PASS    = 3'd1,
        ST_BITERR  = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_UNLOCK  = 3'd4,
        ST_ABORT   = 3'd5
    } status_t;

endpackage

// File: rtl/prl_watchdog.sv
// Stall watchdog: counts idle cycles while enabled, flags the cycle that reaches the limit.
module prl_watchdog #(
    parameter int WD_W = 16
) (
    input  logic            CLK,
    input  logic            RSTX,
    input  logic            clr,
    input  logic            en,
    input  logic [WD_W-1:0] lim,
    output logic            expired
);

    logic [WD_W-1:0] cnt;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    // cnt holds the idle cycles seen before this one, so lim-1 makes this the lim-th.
    assign expired = en && (lim != '0) && (cnt == lim - 1'b1);

endmodule

// File: rtl/parallel_recv_seq.sv
// Bit-error test sequencer: clears the checker, waits for lock, runs NBLK blocks, latches a verdict.
module parallel_recv_seq
    import parallel_pkg::*;
#(
    parameter int CLR_CYC = 4,
    parameter int WD_W    = 16
) (
    input  logic            RSTX,
    input  logic            CLK,
    input  logic            START,
    input  logic            ABORT,
    input  logic            ALIGNED,
    input  logic            DIPUSH,
    input  logic [7:0]      ERR_CNT,
    input  logic [15:0]     NBLK,
    input  logic [WD_W-1:0] WD_LIM,
    output logic            CLR,
    output logic            INIT,
    output logic            HOLD,
    output logic            BUSY,
    output logic            DONE,
    output logic [2:0]      STATUS,
    output logic [7:0]      RES_ERR,
    output logic [15:0]     BLK_DONE
);

    state_t      state, state_nxt;
    status_t     fault;
    logic [9:0]  word_cnt;
    logic [3:0]  cyc_cnt;
    logic [15:0] nblk_eff;
    logic        acc, last_word, last_blk;
    logic        wd_en, wd_clr, wd_exp;

    assign acc       = ALIGNED & DIPUSH;
    assign nblk_eff  = (NBLK == 16'd0) ? 16'd1 : NBLK;
    assign last_word = (word_cnt == 10'(BLK_WORDS - 1));
    assign last_blk  = (({1'b0, BLK_DONE} + 17'd1) == {1'b0, nblk_eff});

    assign wd_en  = state inside {WAITLK, RUN, MARK};
    assign wd_clr = acc || (state_nxt != state);

    prl_watchdog #(.WD_W(WD_W)) u_wd (
        .CLK     (CLK),
        .RSTX    (RSTX),
        .clr     (wd_clr),
        .en      (wd_en),
        .lim     (WD_LIM),
        .expired (wd_exp)
    );

    // NOTE: defaults first so every path assigns state_nxt and fault; no latch is inferred.
    always_comb begin
        state_nxt = state;
        fault     = ST_NONE;
        unique case (state)
            IDLE:    if (START) state_nxt = CLEAR;
            CLEAR:   if (cyc_cnt == 4'(CLR_CYC - 1)) state_nxt = WAITLK;
            WAITLK:  if (ALIGNED) state_nxt = INITB;
            INITB:   state_nxt = RUN;
            RUN:     if (acc && last_word) state_nxt = MARK;
            MARK:    if (acc) state_nxt = last_blk ? DRAIN : INITB;
            DRAIN:   if (cyc_cnt == 4'(DRAIN_CYC - 1)) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Faults applied lowest priority first so the later ones win.
        if (wd_exp && !acc) begin
            fault     = ST_TIMEOUT;
            state_nxt = REPORT;
        end
        if (!ALIGNED && (state inside {INITB, RUN, MARK})) begin
            fault     = ST_UNLOCK;
            state_nxt = REPORT;
        end
        if (ABORT && !(state inside {IDLE, REPORT})) begin
            fault     = ST_ABORT;
            state_nxt = REPORT;
        end
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state    <= IDLE;
            word_cnt <= '0;
            cyc_cnt  <= '0;
            CLR      <= 1'b0;
            INIT     <= 1'b0;
            HOLD     <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            STATUS   <= ST_NONE;
            RES_ERR  <= '0;
            BLK_DONE <= '0;
        end else begin
            state <= state_nxt;
            CLR   <= (state_nxt == CLEAR);
            INIT  <= (state_nxt == INITB);
            HOLD  <= state_nxt inside {CLEAR, WAITLK, INITB, DRAIN};
            BUSY  <= (state_nxt != IDLE);
            DONE  <= (state_nxt == REPORT);

            if (state_nxt != state)
                cyc_cnt <= '0;
            else if (state inside {CLEAR, DRAIN})
                cyc_cnt <= cyc_cnt + 4'd1;

            if (state == IDLE && START) begin
                word_cnt <= '0;
                BLK_DONE <= '0;
                STATUS   <= ST_NONE;
            end

            if (state == RUN && acc)
                word_cnt <= word_cnt + 10'd1;

            if (state == MARK && acc && fault == ST_NONE && BLK_DONE != 16'hFFFF)
                BLK_DONE <= BLK_DONE + 16'd1;

            if (state_nxt == REPORT) begin
                RES_ERR <= ERR_CNT;
                STATUS  <= (fault != ST_NONE) ? fault
                         : ((ERR_CNT == 8'd0) ? ST_PASS : ST_BITERR);
            end
        end
    end

endmodule
